// File: rtl/darkroom_pkg.sv
`default_nettype none
// ============================================================================
// Module  : darkroom_pkg
// Purpose : Shared constants and types for the darkroom event buffer:
//           Avalon register addresses, event entry layout and field widths,
//           drop counter width and the Avalon read-phase state type.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package darkroom_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_EVT_DATA      = 3'd0;
  localparam logic [2:0] ADDR_EVT_TAG       = 3'd1;
  localparam logic [2:0] ADDR_STATUS        = 3'd2;
  localparam logic [2:0] ADDR_ENABLE_MASK   = 3'd3;
  localparam logic [2:0] ADDR_DROP_COUNT    = 3'd4;
  localparam logic [2:0] ADDR_CONTROL       = 3'd5;
  localparam logic [2:0] ADDR_IRQ_THRESHOLD = 3'd6;

  // Event entry layout: {data[31:0], id[7:0], ts[23:0]}
  localparam int EVT_ID_WIDTH   = 8;
  localparam int TS_FIELD_WIDTH = 24;
  localparam int EVT_WIDTH      = 64;
  localparam int EVT_TS_LSB     = 0;
  localparam int EVT_ID_LSB     = 24;
  localparam int EVT_DATA_LSB   = 32;

  localparam int DROP_CNT_WIDTH = 16;

  // Avalon read: first cycle stalls and registers readdata, second completes.
  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage : darkroom_pkg
`default_nettype wire

// File: rtl/darkroom_event_fifo.sv
`default_nettype none
// ============================================================================
// Module  : darkroom_event_fifo
// Purpose : Synchronous show-ahead FIFO. The head entry is visible on data_o
//           whenever empty_o is low. Push when full and pop when empty are
//           ignored; flush empties the FIFO and overrides push/pop.
// Ports   : clock, reset_n     - clock, async active-low reset
//           push_i, data_i     - write strobe and entry
//           pop_i              - remove head entry
//           flush_i            - discard all entries
//           data_o             - head entry
//           full_o, empty_o    - status flags
//           fill_o             - number of stored entries
// Revision: 1.0 - initial release
// ============================================================================
module darkroom_event_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   fill_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      fill_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (fill_q == (AW+1)'(DEPTH));
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      fill_q   <= fill_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; contents are only observed when non-empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule : darkroom_event_fifo
`default_nettype wire

// File: rtl/darkroom_event_buffer.sv
`default_nettype none
// ============================================================================
// Module  : darkroom_event_buffer
// Purpose : Lighthouse sweep aggregator. Captures per-sensor sweep words with
//           a free-running timestamp, arbitrates them round-robin into a
//           shared show-ahead FIFO and exposes FIFO and control/status over
//           Avalon-MM (one read wait state) with a level-threshold interrupt.
// Ports   : clock, reset_n       - clock, async active-low reset
//           sensor_data_i        - 32-bit sweep word per sensor
//           sensor_valid_i       - 1-cycle strobe per sensor
//           address/read/write/writedata/readdata/waitrequest - Avalon-MM
//           irq_o                - level interrupt (fill >= threshold)
// Revision: 1.0 - initial release
// ============================================================================
module darkroom_event_buffer
  import darkroom_pkg::*;
#(
  parameter int NUMBER_OF_SENSORS = 8,
  parameter int FIFO_DEPTH        = 64,
  parameter int TIMESTAMP_WIDTH   = 24
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [32*NUMBER_OF_SENSORS-1:0] sensor_data_i,
  input  logic [NUMBER_OF_SENSORS-1:0]    sensor_valid_i,
  input  logic [2:0]                      address,
  input  logic                            read,
  input  logic                            write,
  input  logic [31:0]                     writedata,
  output logic [31:0]                     readdata,
  output logic                            waitrequest,
  output logic                            irq_o
);

  localparam int N      = NUMBER_OF_SENSORS;
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------- state
  logic [TIMESTAMP_WIDTH-1:0] timestamp_q;
  logic [N-1:0]               pending_q;
  logic [31:0]                data_q [N];
  logic [TIMESTAMP_WIDTH-1:0] ts_q   [N];
  logic [4:0]                 last_grant_q;
  logic [N-1:0]               enable_mask_q;
  logic [DROP_CNT_WIDTH-1:0]  drop_count_q;
  logic                       overflow_q;
  logic                       irq_enable_q;
  logic [15:0]                irq_threshold_q;
  logic [31:0]                readdata_q;
  logic                       rd_pop_q;
  logic                       irq_q;
  rd_state_e                  rd_state_q;
  rd_state_e                  rd_state_d;

  // ---------------------------------------------------------------- wires
  logic                 wr_en;
  logic                 flush;
  logic [N-1:0]         mask_clear;
  logic [31:0]          pend_ext;
  logic                 grant_found;
  logic [4:0]           grant_idx;
  logic [5:0]           cand;
  logic                 grant;
  logic [N-1:0]         granted_vec;
  logic [N-1:0]         capture_vec;
  logic [N-1:0]         drop_vec;
  logic [16:0]          drop_sum;
  logic [EVT_WIDTH-1:0] push_entry;
  logic [EVT_WIDTH-1:0] head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FILL_W-1:0]    fifo_fill;
  logic [15:0]          fill16;
  logic                 rd_start;
  logic                 rd_accept;
  logic                 fifo_pop;
  logic [31:0]          rd_mux;
  logic                 unused_wdata;

  // A read in progress swallows any write presented alongside it.
  assign wr_en      = write & ~read;
  assign flush      = wr_en && (address == ADDR_CONTROL) && writedata[0];
  assign mask_clear = (wr_en && (address == ADDR_ENABLE_MASK)) ? ~writedata[N-1:0] : '0;
  assign unused_wdata = ^writedata;

  // ------------------------------------------------------------- arbiter
  // Search starts at the sensor after the last grant and wraps around.
  assign pend_ext = 32'(pending_q);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N; i++) begin
      cand = 6'(last_grant_q) + 6'(i);
      if (cand >= 6'(N)) begin
        cand = cand - 6'(N);
      end
      if (!grant_found && pend_ext[cand[4:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[4:0];
      end
    end
  end

  assign grant = grant_found & ~fifo_full & ~flush;

  always_comb begin
    granted_vec = '0;
    push_entry  = '0;
    for (int k = 0; k < N; k++) begin
      if (grant && (grant_idx == 5'(k))) begin
        granted_vec[k] = 1'b1;
        push_entry     = {data_q[k], EVT_ID_WIDTH'(k), TS_FIELD_WIDTH'(ts_q[k])};
      end
    end
  end

  // ------------------------------------------------------------- capture
  assign capture_vec = sensor_valid_i & enable_mask_q & {N{~flush}};
  // A capture onto a still-pending slot that is not leaving this cycle
  // overwrites an unread sweep.
  assign drop_vec    = capture_vec & pending_q & ~granted_vec;
  assign drop_sum    = 17'(drop_count_q) + 17'($countones(drop_vec));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timestamp_q  <= '0;
      pending_q    <= '0;
      last_grant_q <= 5'(N - 1);
      for (int k = 0; k < N; k++) begin
        data_q[k] <= '0;
        ts_q[k]   <= '0;
      end
    end else begin
      timestamp_q <= timestamp_q + 1'b1;
      if (grant) begin
        last_grant_q <= grant_idx;
      end
      for (int k = 0; k < N; k++) begin
        if (flush || mask_clear[k]) begin
          pending_q[k] <= 1'b0;
        end else if (capture_vec[k]) begin
          pending_q[k] <= 1'b1;
          data_q[k]    <= sensor_data_i[32*k +: 32];
          ts_q[k]      <= timestamp_q;
        end else if (granted_vec[k]) begin
          pending_q[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------- FIFO
  darkroom_event_fifo #(
    .WIDTH (EVT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push_i  (grant),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .fill_o  (fifo_fill)
  );

  assign fill16 = 16'(fifo_fill);

  // ------------------------------------------------------- Avalon read FSM
  always_comb begin
    rd_state_d = RD_IDLE;
    if (read && (rd_state_q == RD_IDLE)) begin
      rd_state_d = RD_DATA;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_state_q <= RD_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  assign rd_start    = read & (rd_state_q == RD_IDLE);
  assign rd_accept   = read & (rd_state_q == RD_DATA);
  // Gated by reset so an interrupted read is released at once.
  assign waitrequest = rd_start & reset_n;
  // Pop decision is taken with the data snapshot, so an empty-tag read
  // never pops an entry that arrives during the wait state.
  assign fifo_pop    = rd_accept & rd_pop_q;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_EVT_DATA:      rd_mux = fifo_empty ? 32'd0 : head[EVT_DATA_LSB +: 32];
      ADDR_EVT_TAG:       rd_mux = fifo_empty ? 32'd0 : head[EVT_TS_LSB +: 32];
      ADDR_STATUS:        rd_mux = {overflow_q, 15'd0, fill16};
      ADDR_ENABLE_MASK:   rd_mux = 32'(enable_mask_q);
      ADDR_DROP_COUNT:    rd_mux = 32'(drop_count_q);
      ADDR_CONTROL:       rd_mux = {30'd0, irq_enable_q, 1'b0};
      ADDR_IRQ_THRESHOLD: rd_mux = {16'd0, irq_threshold_q};
      default:            rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      rd_pop_q   <= 1'b0;
    end else if (rd_start) begin
      readdata_q <= rd_mux;
      rd_pop_q   <= (address == ADDR_EVT_TAG) & ~fifo_empty;
    end
  end

  assign readdata = readdata_q;

  // ------------------------------------------------------ control/status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enable_mask_q   <= '1;
      drop_count_q    <= '0;
      overflow_q      <= 1'b0;
      irq_enable_q    <= 1'b0;
      irq_threshold_q <= 16'd1;
      irq_q           <= 1'b0;
    end else begin
      irq_q <= irq_enable_q && (fill16 >= irq_threshold_q);

      if (wr_en && (address == ADDR_DROP_COUNT)) begin
        drop_count_q <= '0;
      end else if (drop_sum[16]) begin
        drop_count_q <= '1;
      end else begin
        drop_count_q <= drop_sum[15:0];
      end

      if (grant_found && fifo_full && !flush) begin
        overflow_q <= 1'b1;
      end else if (wr_en && (address == ADDR_STATUS) && writedata[31]) begin
        overflow_q <= 1'b0;
      end

      if (wr_en && (address == ADDR_ENABLE_MASK)) begin
        enable_mask_q <= writedata[N-1:0];
      end
      if (wr_en && (address == ADDR_CONTROL)) begin
        irq_enable_q <= writedata[1];
      end
      if (wr_en && (address == ADDR_IRQ_THRESHOLD)) begin
        irq_threshold_q <= (writedata[15:0] == 16'd0) ? 16'd1 : writedata[15:0];
      end
    end
  end

  assign irq_o = irq_q;

endmodule : darkroom_event_buffer
`default_nettype wire

// File: tb/tb_darkroom_event_buffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_darkroom_event_buffer
// Purpose : Directed self-checking bench for darkroom_event_buffer
//           (8 sensors, 4-entry FIFO, 24-bit timestamp).
// Revision: 1.0 - initial release
// ============================================================================
module tb_darkroom_event_buffer;

  localparam int NS = 8;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_TAG  = 3'd1;
  localparam logic [2:0] A_STAT = 3'd2;
  localparam logic [2:0] A_MASK = 3'd3;
  localparam logic [2:0] A_DROP = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd5;
  localparam logic [2:0] A_THR  = 3'd6;
  localparam logic [2:0] A_RSVD = 3'd7;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [32*NS-1:0]  sensor_data = '0;
  logic [NS-1:0]     sensor_valid = '0;
  logic [2:0]        address = '0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic              waitrequest;
  logic              irq;

  int checks = 0;
  int errors = 0;

  // Reference for the free-running timestamp.
  logic [23:0] tb_ts;

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) tb_ts <= '0;
    else          tb_ts <= tb_ts + 24'd1;
  end

  darkroom_event_buffer #(
    .NUMBER_OF_SENSORS (NS),
    .FIFO_DEPTH        (4),
    .TIMESTAMP_WIDTH   (24)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .sensor_data_i  (sensor_data),
    .sensor_valid_i (sensor_valid),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .readdata       (readdata),
    .waitrequest    (waitrequest),
    .irq_o          (irq)
  );

  // ------------------------------------------------------------ drivers
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    read = 0; write = 0; sensor_valid = '0;
    @(negedge clock);
    reset_n = 0;
    idle(2);
    reset_n = 1;
    idle(1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1;
    @(posedge clock); @(negedge clock);
    d = readdata;
    @(posedge clock); @(negedge clock);
    read = 0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1;
    @(posedge clock); @(negedge clock);
    write = 0;
  endtask

  task automatic pulse(input logic [NS-1:0] m, input logic [31:0] d);
    sensor_valid = m; sensor_data = {NS{d}};
    @(posedge clock); @(negedge clock);
    sensor_valid = '0;
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] d;
    @(negedge clock);
    reset_n = 0; read = 1; address = A_STAT;
    #1;
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL reset_waitreq got %b want 0", waitrequest); end
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    idle(2);
    read = 0; reset_n = 1;
    idle(1);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 00000000", d); end
    bus_read(A_MASK, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL reset_mask got %h want 000000ff", d); end
    bus_read(A_THR, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_thr got %h want 00000001", d); end
    bus_read(A_CTRL, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_drop got %h want 0", d); end
  endtask

  task automatic test_read_timing();
    address = A_MASK; read = 1;
    #1;
    checks++; if (waitrequest !== 1'b1) begin errors++; $display("FAIL rd_wait1 got %b want 1", waitrequest); end
    @(posedge clock); @(negedge clock);
    checks++; if (waitrequest !== 1'b0) begin errors++; $display("FAIL rd_wait2 got %b want 0", waitrequest); end
    checks++; if (readdata !== 32'hFF) begin errors++; $display("FAIL rd_data got %h want 000000ff", readdata); end
    @(posedge clock); @(negedge clock);
    read = 0;
  endtask

  task automatic test_capture();
    logic [31:0] d;
    logic [23:0] t;
    apply_reset();
    t = tb_ts;
    pulse(8'h08, 32'hDEADBEEF);
    idle(2);
    bus_read(A_DATA, d);
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL cap_data got %h want deadbeef", d); end
    bus_read(A_TAG, d);
    checks++; if (d !== (32'h03000000 | {8'h0, t})) begin errors++; $display("FAIL cap_tag got %h want %h", d, 32'h03000000 | {8'h0, t}); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL cap_fill got %h want 0", d); end
  endtask

  task automatic test_round_robin();
    logic [31:0] d;
    logic [7:0]  exp_id [3];
    exp_id[0] = 8'd0; exp_id[1] = 8'd5; exp_id[2] = 8'd7;
    apply_reset();
    pulse(8'hA1, 32'h12345678);
    idle(5);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL rr_fill got %h want 3", d); end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_TAG, d);
      checks++; if (d[31:24] !== exp_id[i]) begin errors++; $display("FAIL rr_id%0d got %0d want %0d", i, d[31:24], exp_id[i]); end
    end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rr_drop got %h want 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    apply_reset();
    sensor_valid = 8'h04; sensor_data = {NS{32'h111}};
    @(posedge clock); @(negedge clock);
    sensor_data = {NS{32'h222}};
    @(posedge clock); @(negedge clock);
    sensor_valid = '0;
    idle(3);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL b2b_fill got %h want 2", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL b2b_drop got %h want 0", d); end
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h111) begin errors++; $display("FAIL b2b_first got %h want 111", d); end
    bus_read(A_TAG, d);
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h222) begin errors++; $display("FAIL b2b_second got %h want 222", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      pulse(8'h04, 32'h100 + i);
      idle(2);
    end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h80000004) begin errors++; $display("FAIL ovf_status got %h want 80000004", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_drop got %h want 1", d); end
    bus_read(A_TAG, d);
    checks++; if (d[31:24] !== 8'd2) begin errors++; $display("FAIL ovf_id got %0d want 2", d[31:24]); end
    idle(2);
    bus_write(A_STAT, 32'h80000000);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h00000004) begin errors++; $display("FAIL ovf_clear got %h want 00000004", d); end
    for (int i = 0; i < 3; i++) bus_read(A_TAG, d);
    bus_read(A_DATA, d);
    checks++; if (d !== 32'h105) begin errors++; $display("FAIL ovf_last got %h want 105", d); end
    bus_read(A_TAG, d);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_empty got %h want 0", d); end
    bus_write(A_DROP, 32'h0);
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL drop_clear got %h want 0", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    apply_reset();
    bus_write(A_THR, 32'd2);
    bus_write(A_CTRL, 32'h2);
    pulse(8'h12, 32'hCAFE0000);
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_one got %b want 0", irq); end
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push2 got %b want 0", irq); end
    idle(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise got %b want 1", irq); end
    bus_read(A_TAG, d);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold got %b want 1", irq); end
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall got %b want 0", irq); end
    bus_write(A_THR, 32'd0);
    bus_read(A_THR, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL thr_zero got %h want 1", d); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    apply_reset();
    pulse(8'h41, 32'hA0);
    pulse(8'h40, 32'hA1);
    idle(2);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL fl_pre_fill got %h want 2", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fl_pre_drop got %h want 1", d); end
    sensor_valid = 8'h02; sensor_data = {NS{32'hB1}};
    address = A_CTRL; writedata = 32'h1; write = 1;
    @(posedge clock); @(negedge clock);
    sensor_valid = '0; write = 0;
    idle(3);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fl_fill got %h want 0", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fl_drop got %h want 1", d); end
    bus_read(A_TAG, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fl_empty_tag got %h want 0", d); end
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fl_fill_after got %h want 0", d); end
  endtask

  task automatic test_enable_mask();
    logic [31:0] d;
    apply_reset();
    bus_write(A_MASK, 32'hFE);
    pulse(8'h01, 32'h55);
    idle(3);
    bus_read(A_STAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_fill got %h want 0", d); end
    bus_read(A_DROP, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mask_drop got %h want 0", d); end
    // Read and write together: the write must be discarded.
    address = A_MASK; writedata = 32'h0; write = 1; read = 1;
    @(posedge clock); @(negedge clock);
    d = readdata;
    @(posedge clock); @(negedge clock);
    read = 0; write = 0;
    checks++; if (d !== 32'hFE) begin errors++; $display("FAIL rw_read got %h want fe", d); end
    bus_read(A_MASK, d);
    checks++; if (d !== 32'hFE) begin errors++; $display("FAIL rw_mask got %h want fe", d); end
    bus_write(A_RSVD, 32'hFFFFFFFF);
    bus_read(A_RSVD, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rsvd got %h want 0", d); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_timing();
    test_capture();
    test_round_robin();
    test_back_to_back();
    test_overflow();
    test_irq();
    test_flush();
    test_enable_mask();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_darkroom_event_buffer
`default_nettype wire

// File: doc/darkroom_event_buffer.md
Name: darkroom_event_buffer

Overview:
- Next-generation lighthouse aggregator. Takes decoded sweep words from up to 32 lighthouse sensor decoders.
- Stamps each event with sensor id and a free-running timestamp, then queues it in a shared FIFO.
- Exposes the FIFO plus control/status registers over Avalon-MM with a fixed read wait state, and raises a level-threshold interrupt.
- Replaces polling of static per-sensor registers: no sweep is lost or read twice unless reported in the drop counter.

Parameters:
NUMBER_OF_SENSORS, 8, sensor channels; legal 1..32
FIFO_DEPTH, 64, event entries; power of two, 4..1024
TIMESTAMP_WIDTH, 24, free-running timestamp width; legal 8..24

Ports:
clock  in  1  system clock
reset_n  in  1  async active-low reset
sensor_data_i  in  32*NUMBER_OF_SENSORS  decoded sweep word per sensor; sensor k at bits [32k+31:32k]
sensor_valid_i  in  NUMBER_OF_SENSORS  1-cycle strobe per sensor, qualifies sensor_data_i
address  in  3  Avalon word address
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data
waitrequest  out  1  Avalon wait
irq_o  out  1  interrupt, level-sensitive

Behaviour:
- Reset (async, reset_n=0; clock is clock):
  - FIFO empty; all pending registers cleared; timestamp=0.
  - enable_mask=all ones (NUMBER_OF_SENSORS bits); drop_count=0; overflow_sticky=0.
  - irq_enable=0; irq_threshold=1.
  - Outputs: readdata=0, irq_o=0, waitrequest=0.
- Timestamp: increments every cycle; wraps modulo 2^TIMESTAMP_WIDTH.
- Capture:
  - On sensor_valid_i[k] with enable_mask[k]=1: pending[k]<=1, data[k]<=sensor_data_i[k], ts[k]<=current timestamp.
  - If pending[k] is already 1 and not granted in the same cycle: overwrite the pending data and increment drop_count (16-bit, saturating at 0xFFFF).
  - valid with enable_mask[k]=0: ignored, not counted.
- Arbiter:
  - Round-robin, one grant per cycle among pending sensors, starting at the sensor after the last granted.
  - A grant pushes the entry {data[31:0], id[7:0], ts zero-extended to 24} and clears pending.
  - FIFO full: no grant, entries stay pending, overflow_sticky<=1.
  - Capture-to-FIFO latency when uncontested and not full: 2 cycles (capture register, then push).
  - Capture and grant of the same sensor in the same cycle: the grant pushes the old data; the new data becomes pending; no drop.
- FIFO: show-ahead. Push and pop in the same cycle leave fill unchanged. A pop when empty is ignored.
- Avalon read:
  - waitrequest = read & ~rd_phase; rd_phase <= read & ~rd_phase. Every read therefore takes exactly 2 cycles.
  - readdata is registered and valid in the cycle waitrequest=0.
  - Writes complete with zero wait.
- Register map (word address):
  - 0 EVT_DATA (RO): head data word; 0 if empty.
  - 1 EVT_TAG (RO): {id[7:0], ts[23:0]} of head; the accepted read pops. Empty: returns 0, no pop.
  - 2 STATUS: bit31 overflow_sticky (write 1 clears); bits[15:0] fill level.
  - 3 ENABLE_MASK (RW): disabling a sensor also clears its pending bit.
  - 4 DROP_COUNT (RO): any write clears it.
  - 5 CONTROL:
    - bit0 flush, write-1, self-clearing: empties FIFO, clears all pending; overrides push/capture in the same cycle; drop_count unchanged.
    - bit1 irq_enable (RW).
  - 6 IRQ_THRESHOLD (RW, 16 bit): a written 0 is stored as 1.
  - 7: reads 0, writes ignored.
- irq_o: registered; equals irq_enable && fill >= irq_threshold. Deasserts one cycle after fill drops below the threshold.
- Simultaneous read and write: read takes priority, the write is dropped.
- Reset mid-read: waitrequest=0 immediately; the pop does not occur.

Decomposition:
- Package darkroom_pkg holds:
  - register address constants;
  - EVT_ID_WIDTH=8 and TS_FIELD_WIDTH=24;
  - event entry width 64 and the field offsets;
  - DROP_CNT_WIDTH=16.
- Sub-module darkroom_event_fifo: synchronous show-ahead FIFO (WIDTH, DEPTH) with push, pop, flush, full, empty and fill outputs.
- Arbiter and capture logic stay inline.

Test Plan:
- Reset, then read STATUS -> 0x00000000; read ENABLE_MASK -> 0x000000FF; irq_o=0.
- valid on sensor 3 with data 0xDEADBEEF at timestamp T -> EVT_DATA=0xDEADBEEF, EVT_TAG=0x03000000|T; after the pop, STATUS fill=0.
- valid on sensors 0, 5 and 7 in the same cycle -> pops return ids 0, 5, 7 in round-robin order; drop_count=0.
- FIFO_DEPTH=4: 6 events from one sensor while FIFO is full -> fill=4, overflow_sticky=1, drop_count=1; write STATUS 0x80000000 -> bit31 clears.
- irq_threshold=2, irq_enable=1 -> irq_o rises one cycle after the second push; after one pop, irq_o falls one cycle later.
- Flush written in the same cycle as valid on sensor 1 -> fill=0, no entry, drop_count unchanged; read of an empty EVT_TAG -> 0, fill stays 0.
